pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WIN_SCORE, 9, score that ends a game (1..15).
- SERVE_FRAMES, 60, frames the ball is held before launch (1..255).
- DEBOUNCE_FRAMES, 3, consecutive equal frame samples needed to accept a button level (1..15).

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock (pixel clock).
- rst_n, in, 1, reset, asynchronous, active-low.
- frame_tick, in, 1, one-cycle pulse at start of vertical blanking.
- miss_left, in, 1, one-cycle pulse: ball passed left edge.
- miss_right, in, 1, one-cycle pulse: ball passed right edge.
- score_reset, in, 1, raw asynchronous button, active-high.
- speed_lsb, in, 1, raw asynchronous switch, active-high.
- speed_msb, in, 1, raw asynchronous switch, active-high.
- state, out, 3, current FSM state encoding.
- ball_hold, out, 1, ball parked at centre.
- ball_run, out, 1, ball moving.
- serve_dir, out, 1, launch direction: 0 = left, 1 = right.
- score_l, out, 4, left player score.
- score_r, out, 4, right player score.
- speed, out, 2, ball speed select.
- point_pulse, out, 1, one-cycle pulse per scored point.
- winner_valid, out, 1, game over.
- winner, out, 1, winning side: 0 = left, 1 = right; valid when winner_valid = 1.

Function
REQ-003 Raw inputs SHALL pass a 2-flop synchroniser, then a debouncer that samples on frame_tick; the debounced level changes only after DEBOUNCE_FRAMES consecutive equal samples.
REQ-004 A "press" SHALL be a one-cycle pulse on the 0->1 transition of debounced score_reset.
REQ-005 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4; encodings 5-7 SHALL return to IDLE on the next cycle.
REQ-006 IDLE: ball_hold=1; on a press -> SERVE, scores cleared, serve_dir=1.
REQ-007 SERVE entry: the serve counter SHALL be cleared and speed SHALL latch {debounced speed_msb, speed_lsb}; speed SHALL be constant outside SERVE entry.
REQ-008 SERVE: ball_hold=1; the counter increments on frame_tick; on the frame_tick that makes it equal SERVE_FRAMES -> PLAY.
REQ-009 PLAY: ball_run=1.
- miss_left alone: score_r+1, serve_dir=0 (serve toward the conceding player), point_pulse, -> POINT.
- miss_right alone: score_l+1, serve_dir=1, point_pulse, -> POINT.
REQ-010 Simultaneous miss_left and miss_right in PLAY SHALL score nothing, keep serve_dir and go to SERVE.
REQ-011 miss_left and miss_right outside PLAY SHALL be ignored.
REQ-012 POINT SHALL last exactly one cycle: -> GAMEOVER if either score equals WIN_SCORE, else -> SERVE.
REQ-013 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-014 GAMEOVER: ball_hold=1, winner_valid=1, winner = side holding WIN_SCORE; it is left only by a press.
REQ-015 A press in SERVE, PLAY, POINT or GAMEOVER SHALL clear both scores, set serve_dir=1, clear winner_valid and enter SERVE.
REQ-016 A press SHALL take priority over a miss in the same cycle (no point is scored).
REQ-017 ball_hold and ball_run SHALL never both be 1.
REQ-018 All outputs SHALL be registered, with one-cycle latency from the qualifying input edge.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- state = IDLE; scores = 0; serve_dir = 1; speed = 0.
- ball_hold = 1; ball_run = 0; point_pulse = 0; winner_valid = 0; winner = 0.
- synchronisers, debouncers and counters cleared.
REQ-020 Reset deassertion SHALL be used synchronously; reset mid-game SHALL discard all scores.

Structure
REQ-021 Package pong_pkg SHALL hold the state encodings, the score width (4) and the speed width (2).
REQ-022 Sub-module frame_debounce (synchroniser plus frame-sampled debouncer, parameter DEBOUNCE_FRAMES) SHALL be instantiated once per raw input (three instances).

Verification
Bench parameters: WIN_SCORE=3, SERVE_FRAMES=4, DEBOUNCE_FRAMES=3.
REQ-023 Start: after reset, hold score_reset high for 3 frame_ticks -> IDLE->SERVE, scores 0/0; after 4 more frame_ticks state=PLAY with ball_run=1.
REQ-024 Bounce filter: score_reset high for only 2 frame_ticks, then low -> no press, state stays IDLE.
REQ-025 Game to win: 3 miss_right pulses, one per PLAY -> score_l = 1, 2, 3.
- Each point gives point_pulse, POINT for 1 cycle and serve_dir=1.
- After the third: GAMEOVER, winner_valid=1, winner=0; further misses ignored.
REQ-026 Simultaneous misses: miss_left and miss_right in the same PLAY cycle -> scores unchanged, no point_pulse, state=SERVE.
REQ-027 Priority and reset: debounced press coinciding with miss_left in PLAY at 2/1 -> scores 0/0, state=SERVE. Then rst_n low mid-SERVE -> all REQ-019 values immediately.
REQ-028 Speed latch: speed switches = 2'b11 debounced before SERVE entry -> speed=3. Changing the switches during PLAY leaves speed=3 until the next SERVE entry.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the pong game controller: FSM encodings, field widths
// and a saturating score helper.
package pong_pkg;

  localparam int STATE_W     = 3;
  localparam int SCORE_W     = 4;
  localparam int SPEED_W     = 2;
  localparam int SERVE_CNT_W = 8;
  localparam int DEB_CNT_W   = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY     = 3'd2;
  localparam logic [STATE_W-1:0] ST_POINT    = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAMEOVER = 3'd4;

  // Increment a score but never step past the winning value.
  function automatic logic [SCORE_W-1:0] sat_inc(
    input logic [SCORE_W-1:0] val,
    input logic [SCORE_W-1:0] limit
  );
    if (val >= limit) return limit;
    return val + 4'd1;
  endfunction

endpackage

// File: rtl/frame_debounce.sv
// Two-flop synchroniser followed by a debouncer that only looks at the input
// on frame_tick and accepts a new level after DEBOUNCE_FRAMES equal samples.
module frame_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic raw_in,
  output logic level
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_FRAMES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 level_q, level_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (frame_tick) begin
      // cnt_q counts earlier differing samples; any agreeing sample restarts it.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, scoring, win detection and speed latch.
// Every output is a flop loaded from the next-state decode.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE       = 9,
  parameter int SERVE_FRAMES    = 60,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               score_reset,
  input  logic               speed_lsb,
  input  logic               speed_msb,
  output logic [STATE_W-1:0] state,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [SPEED_W-1:0] speed,
  output logic               point_pulse,
  output logic               winner_valid,
  output logic               winner
);

  localparam logic [SCORE_W-1:0]     WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SERVE_CNT_W-1:0] SERVE_END = SERVE_CNT_W'(SERVE_FRAMES);

  logic btn_lvl, lsb_lvl, msb_lvl;

  frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_reset (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .raw_in(score_reset), .level(btn_lvl)
  );

  frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_lsb (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .raw_in(speed_lsb), .level(lsb_lvl)
  );

  frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_msb (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .raw_in(speed_msb), .level(msb_lvl)
  );

  logic                   btn_prev_q, btn_prev_d;
  logic [STATE_W-1:0]     state_q, state_d;
  logic [SCORE_W-1:0]     score_l_q, score_l_d;
  logic [SCORE_W-1:0]     score_r_q, score_r_d;
  logic                   serve_dir_q, serve_dir_d;
  logic [SPEED_W-1:0]     speed_q, speed_d;
  logic [SERVE_CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic                   point_pulse_q, point_pulse_d;
  logic                   winner_valid_q, winner_valid_d;
  logic                   winner_q, winner_d;
  logic                   ball_hold_q, ball_hold_d;
  logic                   ball_run_q, ball_run_d;

  logic press;
  logic serve_entry;
  logic clear_game;

  assign press = btn_lvl & ~btn_prev_q;

  always_comb begin
    btn_prev_d    = btn_lvl;
    state_d       = state_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_dir_d   = serve_dir_q;
    speed_d       = speed_q;
    serve_cnt_d   = serve_cnt_q;
    point_pulse_d = 1'b0;
    winner_d      = winner_q;
    serve_entry   = 1'b0;
    clear_game    = 1'b0;

    // A press wins over any miss in the same cycle, in every state but reset.
    case (state_q)
      ST_IDLE: begin
        if (press) clear_game = 1'b1;
      end
      ST_SERVE: begin
        if (press) begin
          clear_game = 1'b1;
        end else if (frame_tick) begin
          serve_cnt_d = serve_cnt_q + 8'd1;
          if (serve_cnt_d == SERVE_END) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (press) begin
          clear_game = 1'b1;
        end else if (miss_left && miss_right) begin
          serve_entry = 1'b1;
        end else if (miss_left) begin
          score_r_d     = sat_inc(score_r_q, WIN_VAL);
          serve_dir_d   = 1'b0;
          point_pulse_d = 1'b1;
          state_d       = ST_POINT;
        end else if (miss_right) begin
          score_l_d     = sat_inc(score_l_q, WIN_VAL);
          serve_dir_d   = 1'b1;
          point_pulse_d = 1'b1;
          state_d       = ST_POINT;
        end
      end
      ST_POINT: begin
        if (press) begin
          clear_game = 1'b1;
        end else if (score_l_q == WIN_VAL || score_r_q == WIN_VAL) begin
          winner_d = (score_r_q == WIN_VAL);
          state_d  = ST_GAMEOVER;
        end else begin
          serve_entry = 1'b1;
        end
      end
      ST_GAMEOVER: begin
        if (press) clear_game = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_game) begin
      score_l_d   = '0;
      score_r_d   = '0;
      serve_dir_d = 1'b1;
      serve_entry = 1'b1;
    end

    // Speed only changes here so a ball in flight keeps a constant pace.
    if (serve_entry) begin
      state_d     = ST_SERVE;
      serve_cnt_d = '0;
      speed_d     = {msb_lvl, lsb_lvl};
    end

    winner_valid_d = (state_d == ST_GAMEOVER);
    ball_run_d     = (state_d == ST_PLAY);
    ball_hold_d    = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                     (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q     <= 1'b0;
      state_q        <= ST_IDLE;
      score_l_q      <= '0;
      score_r_q      <= '0;
      serve_dir_q    <= 1'b1;
      speed_q        <= '0;
      serve_cnt_q    <= '0;
      point_pulse_q  <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_q       <= 1'b0;
      ball_hold_q    <= 1'b1;
      ball_run_q     <= 1'b0;
    end else begin
      btn_prev_q     <= btn_prev_d;
      state_q        <= state_d;
      score_l_q      <= score_l_d;
      score_r_q      <= score_r_d;
      serve_dir_q    <= serve_dir_d;
      speed_q        <= speed_d;
      serve_cnt_q    <= serve_cnt_d;
      point_pulse_q  <= point_pulse_d;
      winner_valid_q <= winner_valid_d;
      winner_q       <= winner_d;
      ball_hold_q    <= ball_hold_d;
      ball_run_q     <= ball_run_d;
    end
  end

  assign state        = state_q;
  assign ball_hold    = ball_hold_q;
  assign ball_run     = ball_run_q;
  assign serve_dir    = serve_dir_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign speed        = speed_q;
  assign point_pulse  = point_pulse_q;
  assign winner_valid = winner_valid_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=3, SERVE_FRAMES=4,
// DEBOUNCE_FRAMES=3; expected values are hand-derived per scenario.
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       miss_left;
  logic       miss_right;
  logic       score_reset;
  logic       speed_lsb;
  logic       speed_msb;
  logic [2:0] state;
  logic       ball_hold;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] speed;
  logic       point_pulse;
  logic       winner_valid;
  logic       winner;

  int tests_run;
  int tests_failed;

  pong_game_ctrl #(
    .WIN_SCORE(3),
    .SERVE_FRAMES(4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .miss_left(miss_left), .miss_right(miss_right),
    .score_reset(score_reset), .speed_lsb(speed_lsb), .speed_msb(speed_msb),
    .state(state), .ball_hold(ball_hold), .ball_run(ball_run),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
    .speed(speed), .point_pulse(point_pulse),
    .winner_valid(winner_valid), .winner(winner)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) cycle();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic serve_to_play(input string tag);
    repeat (3) frame();
    check_val({tag, "_still_serve"}, {5'd0, state}, 8'd1);
    frame();
    check_val({tag, "_play"}, {5'd0, state}, 8'd2);
    check_val({tag, "_run"}, {7'd0, ball_run}, 8'd1);
    check_val({tag, "_hold"}, {7'd0, ball_hold}, 8'd0);
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    cycle();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, {5'd0, state}, 8'd0);
    check_val({tag, "_score_l"}, {4'd0, score_l}, 8'd0);
    check_val({tag, "_score_r"}, {4'd0, score_r}, 8'd0);
    check_val({tag, "_serve_dir"}, {7'd0, serve_dir}, 8'd1);
    check_val({tag, "_speed"}, {6'd0, speed}, 8'd0);
    check_val({tag, "_hold"}, {7'd0, ball_hold}, 8'd1);
    check_val({tag, "_run"}, {7'd0, ball_run}, 8'd0);
    check_val({tag, "_point"}, {7'd0, point_pulse}, 8'd0);
    check_val({tag, "_wvalid"}, {7'd0, winner_valid}, 8'd0);
    check_val({tag, "_winner"}, {7'd0, winner}, 8'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    frame_tick   = 1'b0;
    miss_left    = 1'b0;
    miss_right   = 1'b0;
    score_reset  = 1'b0;
    speed_lsb    = 1'b0;
    speed_msb    = 1'b0;
    repeat (3) cycle();
    check_reset_values("rst");
    rst_n = 1'b1;
    cycle();
    check_val("idle_after_rst", {5'd0, state}, 8'd0);

    // Bounce: only two high samples, then low.
    score_reset = 1'b1;
    settle();
    frame();
    frame();
    score_reset = 1'b0;
    settle();
    repeat (3) frame();
    check_val("bounce_state", {5'd0, state}, 8'd0);
    check_val("bounce_hold", {7'd0, ball_hold}, 8'd1);

    // Start with speed switches at 2'b11.
    score_reset = 1'b1;
    speed_lsb   = 1'b1;
    speed_msb   = 1'b1;
    settle();
    frame();
    frame();
    check_val("start_not_yet", {5'd0, state}, 8'd0);
    frame();
    check_val("start_serve", {5'd0, state}, 8'd1);
    check_val("start_score_l", {4'd0, score_l}, 8'd0);
    check_val("start_score_r", {4'd0, score_r}, 8'd0);
    check_val("start_dir", {7'd0, serve_dir}, 8'd1);
    check_val("start_speed", {6'd0, speed}, 8'd3);
    score_reset = 1'b0;
    settle();
    serve_to_play("s1");

    // Switches change during PLAY; speed must hold until next serve entry.
    speed_lsb = 1'b0;
    speed_msb = 1'b0;
    settle();
    repeat (3) frame();
    check_val("play_speed_hold", {6'd0, speed}, 8'd3);
    check_val("play_still", {5'd0, state}, 8'd2);

    pulse_miss(1'b0, 1'b1);
    check_val("p1_state", {5'd0, state}, 8'd3);
    check_val("p1_score_l", {4'd0, score_l}, 8'd1);
    check_val("p1_pulse", {7'd0, point_pulse}, 8'd1);
    check_val("p1_dir", {7'd0, serve_dir}, 8'd1);
    check_val("p1_no_hold_run", {6'd0, ball_hold, ball_run}, 8'd0);
    cycle();
    check_val("p1_serve", {5'd0, state}, 8'd1);
    check_val("p1_pulse_end", {7'd0, point_pulse}, 8'd0);
    check_val("p1_speed_new", {6'd0, speed}, 8'd0);
    serve_to_play("s2");

    pulse_miss(1'b0, 1'b1);
    check_val("p2_score_l", {4'd0, score_l}, 8'd2);
    check_val("p2_pulse", {7'd0, point_pulse}, 8'd1);
    cycle();
    check_val("p2_serve", {5'd0, state}, 8'd1);
    serve_to_play("s3");

    pulse_miss(1'b0, 1'b1);
    check_val("p3_state", {5'd0, state}, 8'd3);
    check_val("p3_score_l", {4'd0, score_l}, 8'd3);
    cycle();
    check_val("go_state", {5'd0, state}, 8'd4);
    check_val("go_wvalid", {7'd0, winner_valid}, 8'd1);
    check_val("go_winner", {7'd0, winner}, 8'd0);
    check_val("go_hold", {7'd0, ball_hold}, 8'd1);
    pulse_miss(1'b0, 1'b1);
    pulse_miss(1'b1, 1'b0);
    cycle();
    check_val("go_ignore_state", {5'd0, state}, 8'd4);
    check_val("go_ignore_l", {4'd0, score_l}, 8'd3);
    check_val("go_ignore_r", {4'd0, score_r}, 8'd0);

    // New game from GAMEOVER with speed 2'b11.
    score_reset = 1'b1;
    speed_lsb   = 1'b1;
    speed_msb   = 1'b1;
    settle();
    repeat (3) frame();
    check_val("g2_serve", {5'd0, state}, 8'd1);
    check_val("g2_wvalid", {7'd0, winner_valid}, 8'd0);
    check_val("g2_score_l", {4'd0, score_l}, 8'd0);
    check_val("g2_speed", {6'd0, speed}, 8'd3);
    score_reset = 1'b0;
    settle();
    serve_to_play("s4");

    pulse_miss(1'b1, 1'b0);
    check_val("q1_score_r", {4'd0, score_r}, 8'd1);
    check_val("q1_dir", {7'd0, serve_dir}, 8'd0);
    check_val("q1_pulse", {7'd0, point_pulse}, 8'd1);
    cycle();
    serve_to_play("s5");

    // Simultaneous misses: no score, keep direction, back to SERVE.
    pulse_miss(1'b1, 1'b1);
    check_val("sim_state", {5'd0, state}, 8'd1);
    check_val("sim_score_l", {4'd0, score_l}, 8'd0);
    check_val("sim_score_r", {4'd0, score_r}, 8'd1);
    check_val("sim_pulse", {7'd0, point_pulse}, 8'd0);
    check_val("sim_dir", {7'd0, serve_dir}, 8'd0);
    serve_to_play("s6");

    pulse_miss(1'b0, 1'b1);
    cycle();
    serve_to_play("s7");
    pulse_miss(1'b0, 1'b1);
    check_val("q3_score_l", {4'd0, score_l}, 8'd2);
    check_val("q3_score_r", {4'd0, score_r}, 8'd1);
    cycle();
    serve_to_play("s8");

    // Press lands in the same cycle as miss_left.
    score_reset = 1'b1;
    settle();
    frame();
    frame();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    miss_left  = 1'b1;
    cycle();
    miss_left  = 1'b0;
    check_val("prio_state", {5'd0, state}, 8'd1);
    check_val("prio_score_l", {4'd0, score_l}, 8'd0);
    check_val("prio_score_r", {4'd0, score_r}, 8'd0);
    check_val("prio_pulse", {7'd0, point_pulse}, 8'd0);
    check_val("prio_dir", {7'd0, serve_dir}, 8'd1);
    check_val("prio_speed", {6'd0, speed}, 8'd3);

    // Asynchronous reset mid-SERVE.
    cycle();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    score_reset = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    check_val("post_rst_state", {5'd0, state}, 8'd0);
    check_val("post_rst_hold", {7'd0, ball_hold}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
